// File: rtl/alarm_qsys_mm_pkg.sv
// Shared types and constants for the alarm_qsys Avalon-MM block copier.
package alarm_qsys_mm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } copy_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [3:0]  BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/alarm_qsys_mm_copy_master.sv
// Avalon-MM master that copies a block of 32-bit words one read/write pair at a time.
// One request outstanding at any time; abort stops after the in-flight word completes.
module alarm_qsys_mm_copy_master
  import alarm_qsys_mm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BYTES_PER_WORD);

  copy_state_t       state_r;
  copy_state_t       next_s;
  logic [ADDR_W-1:0] cur_src_r;
  logic [ADDR_W-1:0] cur_dst_r;
  logic [LEN_W-1:0]  len_r;
  logic              abort_flag_r;
  logic              active_s;
  logic              abort_seen_s;
  logic              last_word_s;

  assign avm_byteenable = BYTEENABLE_ALL;

  // Next-state decode; an abort seen this cycle counts as if already latched.
  always_comb begin
    next_s       = state_r;
    active_s     = (state_r == RD) || (state_r == RD_WAIT) || (state_r == WR);
    abort_seen_s = abort_flag_r || (active_s && abort);
    last_word_s  = ((words_done + LEN_W'(1)) == len_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len != {LEN_W{1'b0}}) next_s = RD;
          else                      next_s = DONE;
        end else begin
          next_s = IDLE;
        end
      end
      RD: begin
        if (!avm_waitrequest) next_s = RD_WAIT;
        else                  next_s = RD;
      end
      RD_WAIT: begin
        if (avm_readdatavalid) next_s = WR;
        else                   next_s = RD_WAIT;
      end
      WR: begin
        if (!avm_waitrequest) begin
          if (last_word_s || abort_seen_s) next_s = DONE;
          else                             next_s = RD;
        end else begin
          next_s = WR;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= next_s;
  end

  // Datapath and registered bus/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_src_r     <= {ADDR_W{1'b0}};
      cur_dst_r     <= {ADDR_W{1'b0}};
      len_r         <= {LEN_W{1'b0}};
      abort_flag_r  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      words_done    <= {LEN_W{1'b0}};
      avm_address   <= {ADDR_W{1'b0}};
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'h0000_0000;
    end else begin
      busy      <= (next_s == RD) || (next_s == RD_WAIT) || (next_s == WR);
      done      <= (next_s == DONE);
      avm_read  <= (next_s == RD);
      avm_write <= (next_s == WR);
      if (active_s && abort) abort_flag_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (start) begin
            cur_src_r    <= {src_addr[ADDR_W-1:2], 2'b00};
            cur_dst_r    <= {dst_addr[ADDR_W-1:2], 2'b00};
            avm_address  <= {src_addr[ADDR_W-1:2], 2'b00};
            len_r        <= len;
            words_done   <= {LEN_W{1'b0}};
            aborted      <= 1'b0;
            abort_flag_r <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (avm_readdatavalid) begin
            avm_writedata <= avm_readdata;
            avm_address   <= cur_dst_r;
          end
        end
        WR: begin
          if (!avm_waitrequest) begin
            words_done  <= words_done + LEN_W'(1);
            cur_src_r   <= cur_src_r + STEP;
            cur_dst_r   <= cur_dst_r + STEP;
            avm_address <= cur_src_r + STEP;
            if (next_s == DONE) aborted <= abort_seen_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_qsys_mm_copy_master.sv
// Self-checking bench: Avalon slave memory model plus a word-level reference copy model.
module tb_alarm_qsys_mm_copy_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] src_addr = 14'h0;
  logic [13:0] dst_addr = 14'h0;
  logic [11:0] len = 12'h0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic [11:0] words_done;
  logic [13:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] rdata = 32'h0;
  logic        rdv = 1'b0;
  logic        avm_waitrequest;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_qsys_mm_copy_master #(.ADDR_W(14), .LEN_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .words_done(words_done), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_readdata(rdata),
    .avm_readdatavalid(rdv), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  // slave model state
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        log_wr  [0:4095];
  logic [13:0] log_addr[0:4095];
  int          log_n = 0;
  int          rd_total = 0;
  int          wait_cfg = 0;
  int          lat_cfg = 1;
  int          stall_cnt = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = 32'h0;
  logic        bd_we = 1'b0;
  logic [11:0] bd_idx = 12'h0;
  logic [31:0] bd_data = 32'h0;

  int          busy_total = 0;
  int          done_total = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] snap = 64'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  assign avm_waitrequest = (avm_read || avm_write) && (stall_cnt < wait_cfg);

  // Avalon slave: wait states, variable read latency, memory, transaction log
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 0;
      pend_cnt  <= 0;
      rdv       <= 1'b0;
    end else begin
      rdv <= 1'b0;
      if (bd_we) mem[bd_idx] <= bd_data;
      if (avm_read || avm_write) stall_cnt <= avm_waitrequest ? stall_cnt + 1 : 0;
      if (avm_read && !avm_waitrequest) begin
        log_wr[log_n]   <= 1'b0;
        log_addr[log_n] <= avm_address;
        log_n           <= log_n + 1;
        rd_total        <= rd_total + 1;
        if (lat_cfg == 1) begin
          rdv   <= 1'b1;
          rdata <= mem[avm_address[13:2]];
        end else begin
          pend_cnt  <= lat_cfg - 1;
          pend_data <= mem[avm_address[13:2]];
        end
      end else if (pend_cnt != 0) begin
        pend_cnt <= pend_cnt - 1;
        if (pend_cnt == 1) begin
          rdv   <= 1'b1;
          rdata <= pend_data;
        end
      end
      if (avm_write && !avm_waitrequest) begin
        mem[avm_address[13:2]] <= avm_writedata;
        log_wr[log_n]          <= 1'b1;
        log_addr[log_n]        <= avm_address;
        log_n                  <= log_n + 1;
      end
    end
  end

  // bus stability during stalls, busy/done accounting
  always @(negedge clk) begin
    if (reset_n && prev_stall)
      check("bus_stable_during_stall", {16'h0, avm_read, avm_write, avm_address, avm_writedata}, snap);
    prev_stall <= reset_n && avm_waitrequest;
    snap       <= {16'h0, avm_read, avm_write, avm_address, avm_writedata};
    if (busy) busy_total <= busy_total + 1;
    if (done) done_total <= done_total + 1;
  end

  task automatic poke(input logic [13:0] a, input logic [31:0] v);
    bd_we   = 1'b1;
    bd_idx  = a[13:2];
    bd_data = v;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic run_copy(input logic [13:0] s, input logic [13:0] d, input logic [11:0] n,
                          input int abort_at, input bit junk);
    int k, lb, bb, db, rb, cyc, errs, done_cyc;
    bit seen, pulsed;
    logic [13:0] sa, da, a, b;
    sa = {s[13:2], 2'b00};
    da = {d[13:2], 2'b00};
    k  = (abort_at != 0) ? abort_at : int'(n);
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < k; i++) begin
      a = sa + 14'(4 * i);
      b = da + 14'(4 * i);
      ref_mem[b[13:2]] = ref_mem[a[13:2]];
    end
    lb = log_n; bb = busy_total; db = done_total; rb = rd_total;
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0; pulsed = 1'b0; done_cyc = -1;
    for (cyc = 0; cyc < 3000 && !seen; cyc++) begin
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
        check("aborted_at_done", aborted, (abort_at != 0) ? 64'd1 : 64'd0);
        check("busy_low_at_done", busy, 64'd0);
        check("words_done", words_done, 64'(k));
      end else begin
        abort = (abort_at != 0) && !pulsed && ((rd_total - rb) == abort_at);
        if (abort) pulsed = 1'b1;
        start = junk && (cyc == 1);
        if (start) begin
          src_addr = 14'h2AA8; dst_addr = 14'h1550; len = 12'd7;
        end
        @(negedge clk);
      end
    end
    abort = 1'b0;
    start = 1'b0;
    check("done_within_budget", seen, 64'd1);
    if (n == 12'd0) check("zero_len_done_latency", done_cyc, 64'd0);
    repeat (2) @(negedge clk);
    check("done_pulse_count", done_total - db, 64'd1);
    if (wait_cfg == 0 && lat_cfg == 1) check("busy_cycles", busy_total - bb, 64'(3 * k));
    errs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) errs++;
    check("memory_image", errs, 64'd0);
    check("bus_transfer_count", log_n - lb, 64'(2 * k));
    errs = 0;
    for (int j = 0; j < 2 * k; j++) begin
      a = ((j % 2) == 0) ? sa + 14'(4 * (j / 2)) : da + 14'(4 * (j / 2));
      if (log_wr[lb + j] !== 1'((j % 2)) || log_addr[lb + j] !== a) errs++;
    end
    check("bus_address_order", errs, 64'd0);
  endtask

  initial begin
    int n, ab, dc, got;
    logic [13:0] s, d;
    // reset state
    @(negedge clk);
    check("rst_busy", busy, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_aborted", aborted, 64'd0);
    check("rst_rw", {avm_read, avm_write}, 64'd0);
    check("rst_addr_data", {avm_address, avm_writedata}, 64'd0);
    check("rst_words_done", words_done, 64'd0);
    check("byteenable", avm_byteenable, 64'hF);
    reset_n = 1'b1;
    @(negedge clk);

    // basic copy
    poke(14'h0100, 32'h11); poke(14'h0104, 32'h22);
    poke(14'h0108, 32'h33); poke(14'h010C, 32'h44);
    run_copy(14'h0100, 14'h0200, 12'd4, 0, 1'b0);
    check("basic_first_word", mem[14'h0200 >> 2], 64'h11);
    check("basic_last_word", mem[14'h020C >> 2], 64'h44);

    // zero length
    run_copy(14'h0100, 14'h0300, 12'd0, 0, 1'b0);

    // wait states and read latency 2
    wait_cfg = 3; lat_cfg = 2;
    poke(14'h0400, $urandom); poke(14'h0404, $urandom);
    run_copy(14'h0400, 14'h0500, 12'd2, 0, 1'b0);

    // abort during the third word
    wait_cfg = 0; lat_cfg = 1;
    for (int i = 0; i < 8; i++) poke(14'h0600 + 14'(4 * i), $urandom);
    for (int i = 0; i < 8; i++) poke(14'h0700 + 14'(4 * i), 32'hDEAD_0000 + 32'(i));
    run_copy(14'h0600, 14'h0700, 12'd8, 3, 1'b0);

    // wrap and alignment
    poke(14'h3FFC, 32'hCAFE_F00D); poke(14'h0000, 32'h1234_5678);
    run_copy(14'h3FFC, 14'h0003, 12'd2, 0, 1'b0);

    // randomized copies, random bus timing, optional abort and ignored start
    for (int t = 0; t < 8; t++) begin
      wait_cfg = $urandom_range(0, 2);
      lat_cfg  = $urandom_range(1, 3);
      n = $urandom_range(1, 12);
      s = 14'($urandom_range(0, 16383));
      d = 14'($urandom_range(0, 16383));
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      for (int i = 0; i < n; i++) poke({s[13:2], 2'b00} + 14'(4 * i), $urandom);
      run_copy(s, d, 12'(n), ab, 1'($urandom_range(0, 1)));
    end

    // reset in WR, then a fresh single-word copy
    wait_cfg = 0; lat_cfg = 1;
    start = 1'b1; src_addr = 14'h0100; dst_addr = 14'h0900; len = 12'd4;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && got == 0; c++) begin
      if (avm_write) got = 1;
      else @(negedge clk);
    end
    check("reached_write_phase", got, 64'd1);
    dc = done_total;
    reset_n = 1'b0;
    #1;
    check("reset_drops_write", {avm_read, avm_write, busy}, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_done_after_reset", done_total - dc, 64'd0);
    poke(14'h0A00, 32'h5A5A_A5A5);
    run_copy(14'h0A00, 14'h0B00, 12'd1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, observed no end, required $finish");
    $fatal(1, "watchdog");
  end

endmodule
